// File: rtl/player_physics_if.sv
// ---------------------------------------------------------------------------
// player_physics_if
//
// Bundles the signals between the control stage, the player_physics block
// and its consumers (platform generator, renderer, top level).
//
//   fps_counter  control -> physics  free-running frame counter
//   delta_x      control -> physics  signed horizontal step per frame
//   game_state   control -> physics  0 = waiting, nonzero = play requested
//   land         control -> physics  feet overlap a platform
//   player_x     physics -> consumer player left x, 0..SCREEN_W-1
//   player_y     physics -> consumer player top y
//   vy           physics -> consumer signed vertical velocity (neg = up)
//   scroll_dy    physics -> consumer world scroll for this frame
//   score        physics -> consumer saturating height score
//   game_over    physics -> consumer high once the player has died
//   frame_done   physics -> consumer one-cycle pulse after each frame update
//
// Modports: master = whoever drives the frame inputs, slave = player_physics.
// ---------------------------------------------------------------------------
interface player_physics_if #(
    parameter int CNT_W = 20
);
    logic [CNT_W-1:0]   fps_counter;
    logic signed [8:0]  delta_x;
    logic [1:0]         game_state;
    logic               land;

    logic [9:0]         player_x;
    logic [9:0]         player_y;
    logic signed [7:0]  vy;
    logic [7:0]         scroll_dy;
    logic [19:0]        score;
    logic               game_over;
    logic               frame_done;

    modport master (
        output fps_counter, delta_x, game_state, land,
        input  player_x, player_y, vy, scroll_dy, score, game_over, frame_done
    );

    modport slave (
        input  fps_counter, delta_x, game_state, land,
        output player_x, player_y, vy, scroll_dy, score, game_over, frame_done
    );
endinterface

// File: rtl/player_physics.sv
// ---------------------------------------------------------------------------
// player_physics
//
// Per-frame kinematics for the player sprite. Once per frame tick
// (fps_counter all ones) it integrates horizontal motion with screen
// wrap-around and vertical motion with gravity, platform bounce and upward
// scrolling. Motion that would carry the player above SCROLL_LINE is turned
// into world scroll and added to the height score.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   player_physics_if.slave
//           in : fps_counter, delta_x, game_state, land
//           out: player_x, player_y, vy, scroll_dy, score, game_over,
//                frame_done
//
// All outputs are registered; they change only in the cycle after a tick,
// and frame_done pulses in that same cycle.
// ---------------------------------------------------------------------------
module player_physics #(
    parameter int FPS         = 60,
    parameter int CLK         = 25000000,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int START_X     = 300,
    parameter int START_Y     = 400,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 15,
    parameter int SCROLL_LINE = 160
) (
    input  logic            clk,
    input  logic            rst,
    player_physics_if.slave bus
);

    localparam int CNT_W = $clog2(CLK / FPS) + 1;

    // Constants pre-sized to the arithmetic they take part in.
    localparam logic [9:0]         START_X_V     = 10'(START_X);
    localparam logic [9:0]         START_Y_V     = 10'(START_Y);
    localparam logic [9:0]         SCREEN_W_V    = 10'(SCREEN_W);
    localparam logic signed [10:0] SCREEN_W_S    = 11'(SCREEN_W);
    localparam logic signed [10:0] SCREEN_H_S    = 11'(SCREEN_H);
    localparam logic [9:0]         DEATH_Y       = 10'(SCREEN_H - 1);
    localparam logic signed [10:0] SCROLL_LINE_S = 11'(SCROLL_LINE);
    localparam logic [9:0]         SCROLL_LINE_Y = 10'(SCROLL_LINE);
    localparam logic [7:0]         SCROLL_LINE_B = 8'(SCROLL_LINE);
    localparam logic signed [7:0]  JUMP_VY       = 8'(-JUMP_V);
    localparam logic signed [8:0]  GRAVITY_S     = 9'(GRAVITY);
    localparam logic signed [8:0]  MAX_FALL_S    = 9'(MAX_FALL);
    localparam logic signed [7:0]  MAX_FALL_VY   = 8'(MAX_FALL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [9:0]         x_q,         x_d;
    logic [9:0]         y_q,         y_d;
    logic signed [7:0]  vy_q,        vy_d;
    logic [7:0]         scroll_q,    scroll_d;
    logic [19:0]        score_q,     score_d;
    logic               game_over_q, game_over_d;
    logic               frame_done_q, frame_done_d;

    // -----------------------------------------------------------------------
    // Frame tick
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt;
    logic             tick;

    assign frame_cnt = bus.fps_counter;
    assign tick      = &frame_cnt;

    // -----------------------------------------------------------------------
    // Datapath: candidate next values for a PLAY tick
    // -----------------------------------------------------------------------
    logic signed [10:0] xs;          // unwrapped next x
    logic [9:0]         x_wrap;      // next x folded into 0..SCREEN_W-1
    logic signed [10:0] yn;          // unclamped next y
    logic signed [8:0]  vy_g;        // vy after gravity, before the fall cap
    logic signed [7:0]  vy_fall;     // vy after gravity and cap
    logic [7:0]         scroll_amt;  // SCROLL_LINE - yn when above the line
    logic [20:0]        score_sum;   // one extra bit to detect overflow
    logic [19:0]        score_sat;

    always_comb begin
        xs = $signed({1'b0, x_q}) + $signed({{2{bus.delta_x[8]}}, bus.delta_x});

        // |delta_x| < SCREEN_W, so one correction always lands in range. The
        // correction is done modulo 1024, which is exact because the result
        // is known to fit in 0..SCREEN_W-1.
        if (xs < 11'sd0) begin
            x_wrap = xs[9:0] + SCREEN_W_V;
        end else if (xs >= SCREEN_W_S) begin
            x_wrap = xs[9:0] - SCREEN_W_V;
        end else begin
            x_wrap = xs[9:0];
        end

        yn = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});

        vy_g    = $signed({vy_q[7], vy_q}) + GRAVITY_S;
        vy_fall = (vy_g > MAX_FALL_S) ? MAX_FALL_VY : vy_g[7:0];

        // Only consumed when yn < SCROLL_LINE; the distance is at most the
        // jump speed, so the low byte carries it exactly.
        scroll_amt = SCROLL_LINE_B - yn[7:0];

        score_sum = {1'b0, score_q} + {13'd0, scroll_amt};
        score_sat = score_sum[20] ? '1 : score_sum[19:0];
    end

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value before the case statement so
        // that no path through the block leaves one unassigned (no latches).
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vy_d         = vy_q;
        scroll_d     = scroll_q;
        score_d      = score_q;
        game_over_d  = game_over_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    frame_done_d = 1'b1;
                    // Launch: only velocity changes, position moves next frame.
                    if (bus.game_state != 2'd0) begin
                        state_d = PLAY;
                        vy_d    = JUMP_VY;
                    end
                end
            end

            PLAY: begin
                if (tick) begin
                    frame_done_d = 1'b1;
                    x_d          = x_wrap;

                    if (yn >= SCREEN_H_S) begin
                        // Falling off the bottom wins over a bounce on the
                        // same frame; vy keeps its value and freezes.
                        state_d     = DEAD;
                        game_over_d = 1'b1;
                        y_d         = DEATH_Y;
                        scroll_d    = 8'd0;
                    end else begin
                        // land is ignored while rising so the player passes
                        // up through platforms.
                        vy_d = (bus.land && !vy_q[7]) ? JUMP_VY : vy_fall;

                        if (yn < SCROLL_LINE_S) begin
                            y_d      = SCROLL_LINE_Y;
                            scroll_d = scroll_amt;
                            score_d  = score_sat;
                        end else begin
                            y_d      = yn[9:0];
                            scroll_d = 8'd0;
                        end
                    end
                end
            end

            DEAD: begin
                // Everything frozen, including frame_done; only rst leaves.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= START_X_V;
            y_q          <= START_Y_V;
            vy_q         <= 8'sd0;
            scroll_q     <= 8'd0;
            score_q      <= 20'd0;
            game_over_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vy_q         <= vy_d;
            scroll_q     <= scroll_d;
            score_q      <= score_d;
            game_over_q  <= game_over_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.player_x   = x_q;
    assign bus.player_y   = y_q;
    assign bus.vy         = vy_q;
    assign bus.scroll_dy  = scroll_q;
    assign bus.score      = score_q;
    assign bus.game_over  = game_over_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/player_physics.md
Name: player_physics

Overview:
Per-frame kinematics stage for the player sprite. It sits directly downstream of the button/game-state control stage and consumes its `delta_x` and `game_state` outputs. On each frame tick it integrates horizontal motion with screen wrap-around, and vertical motion with gravity, platform bounce and upward scrolling. It produces the player position, the scroll amount for the platform generator, the height score and game-over for the renderer and top level.

Parameters:
FPS, 60, frame rate; sets the frame-tick period.
CLK, 25000000, clock frequency in Hz.
SCREEN_W, 640, horizontal wrap modulus in pixels.
SCREEN_H, 480, death line; player_y at or below it ends the game.
START_X, 300, player x after reset.
START_Y, 400, player y after reset.
JUMP_V, 12, upward speed applied on launch and bounce (px/frame).
GRAVITY, 1, vy increment per frame.
MAX_FALL, 15, maximum positive (downward) vy.
SCROLL_LINE, 160, minimum on-screen y; motion above it becomes scroll.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fps_counter  in  $clog2(CLK/FPS)+1  free-running frame counter; frame tick when all bits are 1
delta_x  in  9 signed  horizontal step per frame from control
game_state  in  2  0 = waiting, nonzero = play requested
land  in  1  feet overlap a platform (from collision block), sampled at tick
player_x  out  10  player left x, 0..SCREEN_W-1
player_y  out  10  player top y
vy  out  8 signed  current vertical velocity (negative = up)
scroll_dy  out  8  pixels the world scrolls down this frame
score  out  20  accumulated scroll height, saturating
game_over  out  1  high in DEAD state
frame_done  out  1  one-cycle pulse the cycle after each tick update

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high, with clock clk.
  - tick = &fps_counter. All state changes happen only on tick cycles, except frame_done clearing and reset.
- Reset values:
  - player_x=START_X, player_y=START_Y, vy=0, scroll_dy=0, score=0, game_over=0, frame_done=0.
  - State = IDLE.
  - Reset mid-operation overrides everything in the same cycle.
- States:
  - IDLE: positions held, vy=0. On tick with game_state!=0, go to PLAY and set vy<=-JUMP_V. Positions do not move that tick.
  - PLAY: per-tick update as described below.
  - DEAD: all outputs frozen, game_over=1. Only rst exits DEAD.
- Horizontal (PLAY):
  - xs = player_x + delta_x, computed signed 11-bit.
  - If xs<0, then x<=xs+SCREEN_W.
  - Else if xs>=SCREEN_W, then x<=xs-SCREEN_W.
  - Else x<=xs.
  - |delta_x| < SCREEN_W, so a single correction always suffices.
- Vertical (PLAY), using current registered values:
  - yn = player_y + vy, computed signed 11-bit.
  - If land && vy>=0, then vy<=-JUMP_V (bounce; land is ignored while rising).
  - Else vy<=min(vy+GRAVITY, MAX_FALL).
  - If yn<SCROLL_LINE: player_y<=SCROLL_LINE, scroll_dy<=SCROLL_LINE-yn, score<=score+(SCROLL_LINE-yn) saturating at 2^20-1.
  - Else: player_y<=yn, scroll_dy<=0.
  - If yn>=SCREEN_H: go to DEAD, game_over<=1, player_y<=SCREEN_H-1, scroll_dy<=0. Death takes priority over bounce in the same tick.
- Latency:
  - delta_x is registered by control on the same tick, so this block applies the previous frame's delta_x (one frame of lag, by design).
  - Outputs change the cycle after a tick. frame_done pulses that same cycle.
- scroll_dy is held until the next tick. Consumers latch it on frame_done.
- A non-tick cycle never changes any output except the frame_done deassertion.

Test Plan:
- Reset then 3 ticks with game_state=0 -> x=300, y=400, vy=0, frame_done pulses 3 times, positions unchanged.
- game_state=1 at tick, then one more tick, land=0 -> first tick vy=-12, y=400; second tick y=388, vy=-11; third tick y=377, vy=-10.
- PLAY with x=638, delta_x=+5 -> x=3. Then x=2, delta_x=-5 -> x=637. Then delta_x=0 -> x unchanged.
- y=170, vy=-12, land=0 -> y=160, scroll_dy=2, score+=2. Next tick vy=-11 -> scroll_dy=11, score+=11.
- y=300, vy=+4, land=1 -> vy=-12, y=304. Repeat with vy=-3, land=1 -> bounce ignored, vy=-2.
- y=470, vy=+12, land=1 -> DEAD, game_over=1, y=479. Further ticks and delta_x leave outputs frozen. rst mid-DEAD -> all reset values next cycle.
